// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: byte-level I2C sequencer that feeds the bit controller one START/WRITE/READ/STOP at a time.
// Optional watchdog enabled by `define I2C_BYTE_CTRL_TIMEOUT_EN (adds timeout_i/timeout_o).
module i2c_master_byte_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ena_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic        ack_i,
  input  logic [7:0]  din_i,
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  input  logic [15:0] timeout_i,
  output logic        timeout_o,
`endif
  output logic        cmd_ack_o,
  output logic        ack_o,
  output logic [7:0]  dout_o,
  output logic        i2c_al_o,
  output logic [3:0]  bit_cmd_o,
  input  logic        bit_ack_i,
  input  logic        bit_al_i,
  input  logic        bit_dat_i,
  output logic        bit_dat_o
);
  localparam logic [3:0] cmd_nop   = 4'b0000;
  localparam logic [3:0] cmd_start = 4'b0001;
  localparam logic [3:0] cmd_stop  = 4'b0010;
  localparam logic [3:0] cmd_write = 4'b0100;
  localparam logic [3:0] cmd_read  = 4'b1000;
  typedef enum logic [2:0] {st_idle, st_start, st_write, st_read, st_ack, st_stop} state_t;
  state_t state;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic go, tmo;
  assign go = (read_i | write_i | stop_i) & ~cmd_ack_o;
  assign dout_o = sr;
  assign bit_dat_o = (state == st_ack) ? ack_i : sr[7];
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  logic [15:0] tcnt;
  // fires on the clock that would bring the stall counter up to timeout_i
  assign tmo = (state != st_idle) && !bit_ack_i && (timeout_i != 16'd0) && (tcnt + 16'd1 == timeout_i);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      tcnt <= 16'd0;
      timeout_o <= 1'b0;
    end else if (!ena_i || state == st_idle || bit_ack_i || tmo) begin
      tcnt <= 16'd0;
      timeout_o <= ena_i & tmo;
    end else begin
      tcnt <= tcnt + 16'd1;
      timeout_o <= 1'b0;
    end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= st_idle;
      bit_cmd_o <= cmd_nop;
      cmd_ack_o <= 1'b0;
      ack_o <= 1'b0;
      i2c_al_o <= 1'b0;
      sr <= 8'h00;
      cnt <= 3'd0;
    end else if (!ena_i) begin
      state <= st_idle;
      bit_cmd_o <= cmd_nop;
      cmd_ack_o <= 1'b0;
      ack_o <= 1'b0;
      i2c_al_o <= 1'b0;
      sr <= 8'h00;
      cnt <= 3'd0;
    end else begin
      cmd_ack_o <= 1'b0;
      i2c_al_o <= bit_al_i;
      if (bit_al_i || tmo) begin
        state <= st_idle;
        bit_cmd_o <= cmd_nop;
        sr <= 8'h00;
        cnt <= 3'd0;
      end else case (state)
        st_idle: if (go) begin
          sr <= din_i;
          cnt <= 3'd7;
          state <= start_i ? st_start : read_i ? st_read : write_i ? st_write : st_stop;
          bit_cmd_o <= start_i ? cmd_start : read_i ? cmd_read : write_i ? cmd_write : cmd_stop;
        end
        st_start: if (bit_ack_i) begin
          state <= read_i ? st_read : st_write;
          bit_cmd_o <= read_i ? cmd_read : cmd_write;
        end
        st_write, st_read: if (bit_ack_i) begin
          sr <= {sr[6:0], bit_dat_i};
          // the ACK bit travels the opposite way: we drive it after a read, sample it after a write
          if (cnt == 3'd0) begin
            state <= st_ack;
            bit_cmd_o <= (state == st_read) ? cmd_write : cmd_read;
          end else cnt <= cnt - 3'd1;
        end
        st_ack: if (bit_ack_i) begin
          ack_o <= bit_dat_i;
          state <= stop_i ? st_stop : st_idle;
          bit_cmd_o <= stop_i ? cmd_stop : cmd_nop;
          cmd_ack_o <= ~stop_i;
        end
        st_stop: if (bit_ack_i) begin
          state <= st_idle;
          bit_cmd_o <= cmd_nop;
          cmd_ack_o <= 1'b1;
        end
        default: state <= st_idle;
      endcase
    end
endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// tb_i2c_master_byte_ctrl: bench acting as register block and bit controller; a per-byte command queue
// predicts every cycle of bit_cmd_o/bit_dat_o/cmd_ack_o/i2c_al_o.
module tb_i2c_master_byte_ctrl;
  localparam logic [3:0] nop = 4'b0000, sta = 4'b0001, sto = 4'b0010, wr = 4'b0100, rd = 4'b1000;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic start_i = 0, stop_i = 0, read_i = 0, write_i = 0, ack_i = 0;
  logic [7:0] din = 8'h00;
  logic cmd_ack_o, ack_o, i2c_al_o, bit_dat_o;
  logic [7:0] dout_o;
  logic [3:0] bit_cmd_o;
  logic bit_ack_i = 0, bit_al_i = 0, bit_dat_i = 0;
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  logic [15:0] timeout_i = 16'd0;
  logic timeout_o;
`endif
  i2c_master_byte_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .start_i(start_i), .stop_i(stop_i),
    .read_i(read_i), .write_i(write_i), .ack_i(ack_i), .din_i(din),
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    .timeout_i(timeout_i), .timeout_o(timeout_o),
`endif
    .cmd_ack_o(cmd_ack_o), .ack_o(ack_o), .dout_o(dout_o), .i2c_al_o(i2c_al_o),
    .bit_cmd_o(bit_cmd_o), .bit_ack_i(bit_ack_i), .bit_al_i(bit_al_i),
    .bit_dat_i(bit_dat_i), .bit_dat_o(bit_dat_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] cmd; logic care; logic dat; logic rsp;} item_t;
  item_t q[$];
  logic [3:0] exp_cmd = nop;
  logic exp_ack = 0, exp_al = 0, exp_care = 0, exp_dat = 0, mon_en = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic rst_chk(input string nm);
    chk({nm, "_bit_cmd"}, bit_cmd_o, nop);
    chk({nm, "_cmd_ack"}, cmd_ack_o, 0);
    chk({nm, "_ack"}, ack_o, 0);
    chk({nm, "_dout"}, dout_o, 8'h00);
    chk({nm, "_al"}, i2c_al_o, 0);
    chk({nm, "_bit_dat"}, bit_dat_o, 0);
  endtask
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      chk("bit_cmd", bit_cmd_o, exp_cmd);
      chk("cmd_ack", cmd_ack_o, exp_ack);
      chk("i2c_al", i2c_al_o, exp_al);
      if (exp_care) chk("bit_dat", bit_dat_o, exp_dat);
    end
  end
  task automatic step();
    @(negedge clk);
    bit_ack_i = 0;
    bit_al_i = 0;
    exp_al = 0;
    exp_ack = 0;
  endtask
  task automatic set_exp(input int k);
    if (k < q.size()) begin
      exp_cmd = q[k].cmd;
      exp_care = q[k].care;
      exp_dat = q[k].dat;
    end else begin
      exp_cmd = nop;
      exp_care = 0;
    end
  endtask
  task automatic drop();
    start_i = 0; stop_i = 0; read_i = 0; write_i = 0;
  endtask
  // one byte request; abort_at >= 0 aborts at that queue item (kind 0: arb loss, 1: reset, 2: ena low)
  task automatic xfer(input logic s, p, r, w, a, input logic [7:0] d, rdat, input logic sack,
                      input int abort_at, input int kind);
    q.delete();
    if (s) q.push_back(item_t'{sta, 1'b0, 1'b0, 1'b0});
    if (r) begin
      for (int i = 7; i >= 0; i--) q.push_back(item_t'{rd, 1'b0, 1'b0, rdat[i]});
      q.push_back(item_t'{wr, 1'b1, a, a});
    end else if (w) begin
      for (int i = 7; i >= 0; i--) q.push_back(item_t'{wr, 1'b1, d[i], d[i]});
      q.push_back(item_t'{rd, 1'b1, a, sack});
    end
    if (p) q.push_back(item_t'{sto, 1'b0, 1'b0, 1'b0});
    step();
    start_i = s; stop_i = p; read_i = r; write_i = w; ack_i = a; din = d;
    set_exp(0);
    for (int k = 0; k < q.size(); k++) begin
      repeat ($urandom_range(0, 2)) step();
      step();
      if (k == abort_at) begin
        if (kind == 0) begin
          bit_al_i = 1;
          exp_al = 1;
          set_exp(q.size());
        end else if (kind == 1) begin
          mon_en = 0;
          rst_n = 0;
          #1 rst_chk("midrst");
        end else begin
          ena = 0;
          set_exp(q.size());
        end
        step();
        drop();
        set_exp(q.size());
        if (kind == 1) begin
          rst_n = 1;
          mon_en = 1;
        end else chk("abort_dout", dout_o, 8'h00);
        ena = 1;
        repeat (3) step();
        return;
      end
      bit_ack_i = 1;
      bit_dat_i = q[k].rsp;
      set_exp(k + 1);
      if (k == q.size() - 1) exp_ack = 1;
    end
    step();
    drop();
    if (r) begin
      chk("dout", dout_o, rdat);
      chk("ack_o", ack_o, a);
    end else if (w) begin
      chk("dout", dout_o, d);
      chk("ack_o", ack_o, sack);
    end
    repeat (2) step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    #12 rst_chk("reset");
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    xfer(1, 0, 0, 1, 0, 8'hA5, 8'h00, 0, -1, 0);
    chk("t1_ack_lit", ack_o, 1'b0);
    chk("t1_dout_lit", dout_o, 8'hA5);
    xfer(0, 0, 1, 0, 1, 8'h00, 8'h69, 0, -1, 0);
    chk("t2_dout_lit", dout_o, 8'h69);
    chk("t2_ack_lit", ack_o, 1'b1);
    xfer(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, -1, 0);
    xfer(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, -1, 0);
    xfer(1, 1, 1, 0, 1, 8'h00, 8'hC3, 0, -1, 0);
    chk("t5_dout_lit", dout_o, 8'hC3);
    xfer(0, 0, 0, 1, 0, 8'h3C, 8'h00, 1, -1, 0);
    chk("t6_nack_lit", ack_o, 1'b1);
    xfer(0, 0, 0, 1, 0, 8'hF0, 8'h00, 0, 3, 0);
    xfer(1, 0, 0, 1, 0, 8'h5A, 8'h00, 0, 4, 1);
    xfer(0, 0, 1, 0, 0, 8'h00, 8'h96, 0, 2, 2);
    xfer(0, 0, 1, 0, 0, 8'h00, 8'h81, 0, -1, 0);
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    mon_en = 0;
    timeout_i = 16'd20;
    step();
    write_i = 1;
    din = 8'h81;
    @(posedge clk) #2 chk("to_cmd", bit_cmd_o, wr);
    for (int j = 1; j < 20; j++) begin
      @(posedge clk) #2 chk("to_early", timeout_o, 0);
      chk("to_hold", bit_cmd_o, wr);
    end
    @(posedge clk) #2 chk("to_pulse", timeout_o, 1);
    chk("to_nop", bit_cmd_o, nop);
    chk("to_noack", cmd_ack_o, 0);
    @(negedge clk) drop();
    @(posedge clk) #2 chk("to_clear", timeout_o, 0);
    chk("to_idle", bit_cmd_o, nop);
    timeout_i = 16'd0;
    step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
